// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit 2:1 mux between requesters A and B,
// feeding a single-entry registered output stage with per-source transfer counters.
module rr_mux_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    // Handshake: a word moves across any valid/ready pair on a rising edge where
    // both are high; senders hold valid and data stable until that edge.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic             last;
    logic             load;
    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] mux_data;

    // The stage state is the output valid, so the FSM is visible on out_valid.
    assign out_valid = (state == FULL);

    // The stage can take a word when empty, or when its current word leaves this cycle.
    assign load = !out_valid || out_ready;

    // Ties and idle cycles point at the source that did not win last.
    always_comb begin
        grant = ~last;
        if (a_valid && !b_valid) begin
            grant = 1'b0;
        end else if (b_valid && !a_valid) begin
            grant = 1'b1;
        end
    end

    assign sel      = grant;
    assign a_ready  = load && a_valid && !grant;
    assign b_ready  = load && b_valid && grant;
    assign accept   = a_ready || b_ready;
    assign mux_data = sel ? b_data : a_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_src  <= 1'b0;
            last     <= 1'b1;
            cnt_a    <= '0;
            cnt_b    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    // accept in FULL implies out_ready, so the old word is popped as the new one lands
                    if (!accept && out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase

            if (accept) begin
                out_data <= mux_data;
                out_src  <= grant;
                last     <= grant;
                if (grant) begin
                    cnt_b <= cnt_b + CNT_W'(1);
                end else begin
                    cnt_a <= cnt_a + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: a reference model predicts grants and
// pushes accepted words into an expected queue checked against the output stage.
module tb_rr_mux_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    rr_mux_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // scoreboard: {src, data} of every word the model says was accepted
    logic [WIDTH:0] exp_q[$];
    logic             m_full;
    logic             m_last;
    logic [CNT_W-1:0] m_cnt_a;
    logic [CNT_W-1:0] m_cnt_b;
    bit               a_fire;
    bit               b_fire;

    always @(negedge clk) begin
        logic m_load, m_grant, m_ar, m_br;
        a_fire = 1'b0;
        b_fire = 1'b0;
        if (!rst_n) begin
            m_full  = 1'b0;
            m_last  = 1'b1;
            m_cnt_a = '0;
            m_cnt_b = '0;
            exp_q.delete();
        end else begin
            m_load  = !m_full || out_ready;
            m_grant = (a_valid ^ b_valid) ? b_valid : ~m_last;
            m_ar    = m_load && a_valid && !m_grant;
            m_br    = m_load && b_valid && m_grant;
            check("mon_sel",       64'(sel),       64'(m_grant));
            check("mon_a_ready",   64'(a_ready),   64'(m_ar));
            check("mon_b_ready",   64'(b_ready),   64'(m_br));
            check("mon_out_valid", 64'(out_valid), 64'(m_full));
            check("mon_cnt_a",     64'(cnt_a),     64'(m_cnt_a));
            check("mon_cnt_b",     64'(cnt_b),     64'(m_cnt_b));
            if (m_full) begin
                if (exp_q.size() == 0) begin
                    check("mon_queue_nonempty", 64'(0), 64'(1));
                end else begin
                    check("mon_out_data", 64'(out_data), 64'(exp_q[0][WIDTH-1:0]));
                    check("mon_out_src",  64'(out_src),  64'(exp_q[0][WIDTH]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (m_ar || m_br) begin
                exp_q.push_back({m_grant, m_grant ? b_data : a_data});
                m_last = m_grant;
                if (m_grant) m_cnt_b = m_cnt_b + 16'd1;
                else         m_cnt_a = m_cnt_a + 16'd1;
            end
            a_fire = m_ar;
            b_fire = m_br;
            m_full = m_ar || m_br || (m_full && !out_ready);
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        out_ready = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    logic [WIDTH-1:0] exp_words[4];
    logic             exp_srcs[4];

    initial begin
        a_data = '0;
        b_data = '0;
        reset_dut();

        // reset state
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sel",       64'(sel),       64'(0));
        check("rst_a_ready",   64'(a_ready),   64'(0));
        check("rst_b_ready",   64'(b_ready),   64'(0));
        check("rst_cnt_a",     64'(cnt_a),     64'(0));
        check("rst_cnt_b",     64'(cnt_b),     64'(0));
        check("rst_out_data",  64'(out_data),  64'(0));

        // single A transfer
        a_valid = 1'b1; a_data = 32'd5; out_ready = 1'b1;
        #1;
        check("a_only_ready", 64'(a_ready), 64'(1));
        cyc();
        a_valid = 1'b0;
        check("a_only_out_valid", 64'(out_valid), 64'(1));
        check("a_only_out_data",  64'(out_data),  64'(5));
        check("a_only_out_src",   64'(out_src),   64'(0));
        check("a_only_cnt_a",     64'(cnt_a),     64'(1));

        // alternation under a continuous tie
        reset_dut();
        exp_words = '{32'd13, 32'd66, 32'd13, 32'd66};
        exp_srcs  = '{1'b0, 1'b1, 1'b0, 1'b1};
        a_valid = 1'b1; a_data = 32'd13;
        b_valid = 1'b1; b_data = 32'd66;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("tie_out_data", 64'(out_data), 64'(exp_words[i]));
            check("tie_out_src",  64'(out_src),  64'(exp_srcs[i]));
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check("tie_cnt_a", 64'(cnt_a), 64'(2));
        check("tie_cnt_b", 64'(cnt_b), 64'(2));
        cyc();

        // backpressure holds the stage
        a_valid = 1'b1; a_data = 32'd749; out_ready = 1'b0;
        cyc();
        a_valid = 1'b0;
        b_valid = 1'b1; b_data = 32'd619;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_b_ready",  64'(b_ready),  64'(0));
            check("bp_out_data", 64'(out_data), 64'(749));
            cyc();
        end
        out_ready = 1'b1;
        #1;
        check("bp_refill_b_ready", 64'(b_ready), 64'(1));
        cyc();
        b_valid = 1'b0;
        check("bp_refill_data", 64'(out_data), 64'(619));
        check("bp_refill_src",  64'(out_src),  64'(1));
        cyc();

        // cnt_b wraps after 2^CNT_W transfers
        reset_dut();
        b_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
            b_data = $urandom;
            cyc();
        end
        check("wrap_cnt_b_max", 64'(cnt_b), 64'((1 << CNT_W) - 1));
        b_data = $urandom;
        cyc();
        b_valid = 1'b0;
        check("wrap_cnt_b_zero", 64'(cnt_b), 64'(0));
        check("wrap_cnt_a",      64'(cnt_a), 64'(0));
        cyc();

        // random traffic, requesters hold until accepted
        for (int i = 0; i < 400; i++) begin
            if (!a_valid || a_fire) begin
                a_valid = 1'($urandom_range(0, 1));
                a_data  = $urandom;
            end
            if (!b_valid || b_fire) begin
                b_valid = 1'($urandom_range(0, 1));
                b_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        cyc();
        cyc();

        // asynchronous reset discards the held word
        a_valid = 1'b1; a_data = 32'd4932; out_ready = 1'b0;
        cyc();
        a_valid = 1'b0;
        check("arst_pre_valid", 64'(out_valid), 64'(1));
        check("arst_pre_data",  64'(out_data),  64'(4932));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_out_data",  64'(out_data),  64'(0));
        cyc();
        rst_n = 1'b1;
        a_valid = 1'b1; a_data = $urandom;
        b_valid = 1'b1; b_data = $urandom;
        out_ready = 1'b1;
        #1;
        check("arst_tie_sel",     64'(sel),     64'(0));
        check("arst_tie_a_ready", 64'(a_ready), 64'(1));
        check("arst_tie_b_ready", 64'(b_ready), 64'(0));
        cyc();
        a_valid = 1'b0; b_valid = 1'b0;
        check("arst_tie_src",  64'(out_src),  64'(0));
        check("arst_tie_data", 64'(out_data), 64'(a_data));
        cyc();
        cyc();

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
